exception_sequencer: RTL and testbench

- Multicycle sequencer that drives the PC-source selection interface when an exception fires.
- On an exception request it does four things in order: captures EPC, reads the one-byte handler vector from memory, builds the 32-bit handler address, then requests a PC write with the exception source selected.
- Sits beside the main control unit.
- Its pc_source/pc_write are OR-merged by the control unit while busy=1; the control unit yields the PC path for the duration.

---
 rtl/exception_sequencer.sv | 177 +++++++++++++++++
 tb/tb_exception_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_sequencer.sv
// exception_sequencer
// -------------------
// Multicycle sequencer that redirects the PC when an exception fires. On a
// request it captures the return address into EPC, fetches the one-byte
// handler vector from memory, and finally requests a PC write with the
// exception-address source selected. While busy is high the main control
// unit ORs pc_source/pc_write from this block into its own and leaves the PC
// path alone.
//
// Ports:
//   clk            rising-edge system clock
//   reset_n        asynchronous active-low reset
//   excp_opcode    invalid-opcode request   (level, looked at only when idle)
//   excp_overflow  ALU overflow request     (level, looked at only when idle)
//   excp_div0      divide-by-zero request   (level, looked at only when idle)
//   pc_in          current PC (already PC+4)
//   mem_rdata      byte returned by memory for mem_addr
//   mem_addr       vector byte address
//   mem_rd         memory read strobe
//   epc_out        saved exception PC
//   epc_write      one-cycle EPC load pulse
//   excp_out       handler address (zero-extended vector byte)
//   pc_source      PC source select request
//   pc_write       one-cycle PC load pulse
//   excp_cause     0 none, 1 opcode, 2 overflow, 3 div0
//   busy           high in every state except IDLE
//
// Every output is a register; the combinational process computes the value
// each output takes on the next edge.

module exception_sequencer #(
  parameter int VEC_OPCODE   = 253,
  parameter int VEC_OVERFLOW = 254,
  parameter int VEC_DIV0     = 255,
  parameter int MEM_LAT      = 1,
  parameter int PCSRC_EXCP   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        excp_opcode,
  input  logic        excp_overflow,
  input  logic        excp_div0,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] excp_out,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic [1:0]  excp_cause,
  output logic        busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_READ = 2'd2,
    ST_JUMP = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [31:0]        mem_addr_s;
  logic               mem_rd_s;
  logic [31:0]        epc_out_s;
  logic               epc_write_s;
  logic [31:0]        excp_out_s;
  logic [2:0]         pc_source_s;
  logic               pc_write_s;
  logic [1:0]         excp_cause_s;
  logic               busy_s;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    mem_addr_s   = mem_addr;
    epc_out_s    = epc_out;
    excp_out_s   = excp_out;
    excp_cause_s = excp_cause;
    mem_rd_s     = 1'b0;
    epc_write_s  = 1'b0;
    pc_source_s  = 3'd0;
    pc_write_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Fixed priority; a lower-priority request that coincides is simply
        // not serviced. EPC is loaded on this edge so that it is already
        // valid while the epc_write pulse is high during SAVE.
        if (excp_opcode) begin
          excp_cause_s = 2'd1;
          mem_addr_s   = 32'(VEC_OPCODE);
          state_s      = ST_SAVE;
        end else if (excp_overflow) begin
          excp_cause_s = 2'd2;
          mem_addr_s   = 32'(VEC_OVERFLOW);
          state_s      = ST_SAVE;
        end else if (excp_div0) begin
          excp_cause_s = 2'd3;
          mem_addr_s   = 32'(VEC_DIV0);
          state_s      = ST_SAVE;
        end else begin
          state_s      = ST_IDLE;
        end
        if (state_s == ST_SAVE) begin
          epc_write_s = 1'b1;
          epc_out_s   = pc_in - 32'd4;
        end else begin
          epc_write_s = 1'b0;
        end
      end
      ST_SAVE: begin
        mem_rd_s = 1'b1;
        cnt_s    = CNT_W'(MEM_LAT - 1);
        state_s  = ST_READ;
      end
      ST_READ: begin
        // Only the byte present on the final READ edge is taken.
        if (cnt_r == '0) begin
          excp_out_s  = {24'd0, mem_rdata};
          pc_source_s = 3'(PCSRC_EXCP);
          pc_write_s  = 1'b1;
          state_s     = ST_JUMP;
        end else begin
          cnt_s    = cnt_r - CNT_W'(1);
          mem_rd_s = 1'b1;
        end
      end
      ST_JUMP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State, counter and registered outputs; reset clears everything at once,
  // which also aborts any sequence in flight without a late pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      mem_addr   <= 32'd0;
      mem_rd     <= 1'b0;
      epc_out    <= 32'd0;
      epc_write  <= 1'b0;
      excp_out   <= 32'd0;
      pc_source  <= 3'd0;
      pc_write   <= 1'b0;
      excp_cause <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      mem_addr   <= mem_addr_s;
      mem_rd     <= mem_rd_s;
      epc_out    <= epc_out_s;
      epc_write  <= epc_write_s;
      excp_out   <= excp_out_s;
      pc_source  <= pc_source_s;
      pc_write   <= pc_write_s;
      excp_cause <= excp_cause_s;
      busy       <= busy_s;
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Testbench for exception_sequencer. Two instances share clock, reset and
// pc_in: dut1 uses MEM_LAT=1, dut3 uses MEM_LAT=3. Expected jump results are
// queued when a request is driven and checked when pc_write is seen.

module tb_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_in;

  logic        excp_opcode, excp_overflow, excp_div0;
  logic [7:0]  mem_rdata;
  logic [31:0] mem_addr_1, epc_out_1, excp_out_1;
  logic        mem_rd_1, epc_write_1, pc_write_1, busy_1;
  logic [2:0]  pc_source_1;
  logic [1:0]  excp_cause_1;

  logic        excp_opcode_3, excp_overflow_3, excp_div0_3;
  logic [7:0]  mem_rdata_3;
  logic [31:0] mem_addr_3, epc_out_3, excp_out_3;
  logic        mem_rd_3, epc_write_3, pc_write_3, busy_3;
  logic [2:0]  pc_source_3;
  logic [1:0]  excp_cause_3;

  typedef struct packed {
    logic [31:0] epc;
    logic [31:0] excp;
    logic [31:0] addr;
    logic [1:0]  cause;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .excp_opcode(excp_opcode), .excp_overflow(excp_overflow), .excp_div0(excp_div0),
    .pc_in(pc_in), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr_1), .mem_rd(mem_rd_1), .epc_out(epc_out_1), .epc_write(epc_write_1),
    .excp_out(excp_out_1), .pc_source(pc_source_1), .pc_write(pc_write_1),
    .excp_cause(excp_cause_1), .busy(busy_1)
  );

  exception_sequencer #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .excp_opcode(excp_opcode_3), .excp_overflow(excp_overflow_3), .excp_div0(excp_div0_3),
    .pc_in(pc_in), .mem_rdata(mem_rdata_3),
    .mem_addr(mem_addr_3), .mem_rd(mem_rd_3), .epc_out(epc_out_3), .epc_write(epc_write_3),
    .excp_out(excp_out_3), .pc_source(pc_source_3), .pc_write(pc_write_3),
    .excp_cause(excp_cause_3), .busy(busy_3)
  );

  // Scoreboard monitor: every pc_write pulse must match the oldest queued entry.
  initial begin
    exp_t e;
    logic prev1;
    logic prev3;
    prev1 = 1'b0;
    prev3 = 1'b0;
    forever begin
      @(negedge clk);
      if (pc_write_1) begin
        n_vec++;
        if (prev1) begin
          n_err++;
          $display("FAIL dut1_pcw_width: pc_write high for a second cycle, required single pulse");
        end else if (q1.size() == 0) begin
          n_err++;
          $display("FAIL dut1_pcw_unexpected: pc_write=1 with no sequence expected");
        end else begin
          e = q1.pop_front();
          if ({epc_out_1, excp_out_1, mem_addr_1, excp_cause_1, pc_source_1} !==
              {e.epc, e.excp, e.addr, e.cause, 3'd5}) begin
            n_err++;
            $display("FAIL dut1_jump: got epc=%h excp=%h addr=%h cause=%0d src=%0d, required epc=%h excp=%h addr=%h cause=%0d src=5",
                     epc_out_1, excp_out_1, mem_addr_1, excp_cause_1, pc_source_1,
                     e.epc, e.excp, e.addr, e.cause);
          end
        end
      end
      if (pc_write_3) begin
        n_vec++;
        if (prev3) begin
          n_err++;
          $display("FAIL dut3_pcw_width: pc_write high for a second cycle, required single pulse");
        end else if (q3.size() == 0) begin
          n_err++;
          $display("FAIL dut3_pcw_unexpected: pc_write=1 with no sequence expected");
        end else begin
          e = q3.pop_front();
          if ({epc_out_3, excp_out_3, mem_addr_3, excp_cause_3, pc_source_3} !==
              {e.epc, e.excp, e.addr, e.cause, 3'd5}) begin
            n_err++;
            $display("FAIL dut3_jump: got epc=%h excp=%h addr=%h cause=%0d src=%0d, required epc=%h excp=%h addr=%h cause=%0d src=5",
                     epc_out_3, excp_out_3, mem_addr_3, excp_cause_3, pc_source_3,
                     e.epc, e.excp, e.addr, e.cause);
          end
        end
      end
      prev1 = pc_write_1;
      prev3 = pc_write_3;
    end
  end

  // One dut1 sequence: requests driven at a negedge, SAVE cycle checked,
  // requests dropped, then busy/mem_rd/epc_write counted over a bounded window.
  task automatic run_seq1(input logic [2:0] req, input logic [31:0] pc, input logic [7:0] rdata,
                          input logic [31:0] exp_addr, input logic [1:0] exp_cause,
                          input logic [31:0] exp_epc);
    int nbusy, nrd, nepc;
    @(negedge clk);
    {excp_opcode, excp_overflow, excp_div0} = req;
    pc_in = pc;
    mem_rdata = rdata;
    q1.push_back('{epc: exp_epc, excp: {24'd0, rdata}, addr: exp_addr, cause: exp_cause});
    @(negedge clk);
    n_vec++;
    if ({busy_1, epc_write_1, mem_rd_1, epc_out_1, mem_addr_1, excp_cause_1} !==
        {1'b1, 1'b1, 1'b0, exp_epc, exp_addr, exp_cause}) begin
      n_err++;
      $display("FAIL save_cycle: got busy=%b epcw=%b rd=%b epc=%h addr=%h cause=%0d, required 1 1 0 %h %h %0d",
               busy_1, epc_write_1, mem_rd_1, epc_out_1, mem_addr_1, excp_cause_1,
               exp_epc, exp_addr, exp_cause);
    end
    {excp_opcode, excp_overflow, excp_div0} = 3'b000;
    nbusy = 1; nrd = 0; nepc = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_1) nbusy++;
      if (mem_rd_1) nrd++;
      if (epc_write_1) nepc++;
    end
    n_vec++;
    if (nbusy != 3 || nrd != 1 || nepc != 1) begin
      n_err++;
      $display("FAIL seq_counts: got busy=%0d rd=%0d epcw=%0d cycles, required 3 1 1",
               nbusy, nrd, nepc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    excp_opcode = 1'b1; excp_overflow = 1'b1; excp_div0 = 1'b0;
    excp_opcode_3 = 1'b0; excp_overflow_3 = 1'b0; excp_div0_3 = 1'b0;
    pc_in = 32'h0000_0040; mem_rdata = 8'h5A; mem_rdata_3 = 8'h00;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({mem_addr_1, mem_rd_1, epc_out_1, epc_write_1, excp_out_1, pc_source_1, pc_write_1,
         excp_cause_1, busy_1} !== 105'd0) begin
      n_err++;
      $display("FAIL reset_dut1: outputs not all zero (addr=%h epc=%h excp=%h busy=%b cause=%0d)",
               mem_addr_1, epc_out_1, excp_out_1, busy_1, excp_cause_1);
    end
    n_vec++;
    if ({mem_addr_3, mem_rd_3, epc_out_3, epc_write_3, excp_out_3, pc_source_3, pc_write_3,
         excp_cause_3, busy_3} !== 105'd0) begin
      n_err++;
      $display("FAIL reset_dut3: outputs not all zero (addr=%h busy=%b)", mem_addr_3, busy_3);
    end
    reset_n = 1'b1;
    q1.push_back('{epc: 32'h0000_003C, excp: 32'h0000_005A, addr: 32'd253, cause: 2'd1});
    @(negedge clk);
    n_vec++;
    if ({busy_1, epc_write_1, excp_cause_1} !== {1'b1, 1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b epcw=%b cause=%0d, required 1 1 1",
               busy_1, epc_write_1, excp_cause_1);
    end
    excp_opcode = 1'b0; excp_overflow = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if (busy_1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_seq_done: busy=%b, required 0", busy_1);
    end
  endtask

  task automatic test_overflow();
    run_seq1(3'b010, 32'h0000_0010, 8'h3C, 32'd254, 2'd2, 32'h0000_000C);
  endtask

  task automatic test_simultaneous();
    run_seq1(3'b101, 32'h0000_1000, 8'h21, 32'd253, 2'd1, 32'h0000_0FFC);
    n_vec++;
    if ({busy_1, excp_cause_1, mem_addr_1} !== {1'b0, 2'd1, 32'd253}) begin
      n_err++;
      $display("FAIL simul_dropped: busy=%b cause=%0d addr=%h, required 0 1 000000fd",
               busy_1, excp_cause_1, mem_addr_1);
    end
  endtask

  task automatic test_latency();
    int nbusy, nrd, bad_addr;
    @(negedge clk);
    excp_div0_3 = 1'b1;
    pc_in = 32'h0000_0100;
    mem_rdata_3 = 8'h11;
    q3.push_back('{epc: 32'h0000_00FC, excp: 32'h0000_0077, addr: 32'd255, cause: 2'd3});
    nbusy = 0; nrd = 0; bad_addr = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) excp_div0_3 = 1'b0;
      if (busy_3) nbusy++;
      if (mem_rd_3) begin
        nrd++;
        if (mem_addr_3 !== 32'd255) bad_addr++;
        if (nrd == 1) mem_rdata_3 = 8'h22;
        if (nrd == 3) mem_rdata_3 = 8'h77;
      end
    end
    n_vec++;
    if (nbusy != 5 || nrd != 3 || bad_addr != 0) begin
      n_err++;
      $display("FAIL latency: got busy=%0d rd=%0d bad_addr=%0d, required 5 3 0",
               nbusy, nrd, bad_addr);
    end
  endtask

  task automatic test_wrap_hold();
    int nbusy;
    @(negedge clk);
    excp_opcode = 1'b1;
    pc_in = 32'h0000_0000;
    mem_rdata = 8'h80;
    q1.push_back('{epc: 32'hFFFF_FFFC, excp: 32'h0000_0080, addr: 32'd253, cause: 2'd1});
    @(negedge clk);
    n_vec++;
    if (epc_out_1 !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_epc: got %h, required fffffffc", epc_out_1);
    end
    excp_opcode = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_rd_1 !== 1'b1) begin
      n_err++;
      $display("FAIL hold_read: mem_rd=%b, required 1", mem_rd_1);
    end
    excp_overflow = 1'b1;
    @(negedge clk);
    excp_overflow = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_1) nbusy++;
    end
    n_vec++;
    if (nbusy != 0 || {excp_cause_1, mem_addr_1, excp_out_1, epc_out_1} !==
        {2'd1, 32'd253, 32'h0000_0080, 32'hFFFF_FFFC}) begin
      n_err++;
      $display("FAIL hold_ignore: busy_cycles=%0d cause=%0d addr=%h excp=%h epc=%h, required 0 1 000000fd 00000080 fffffffc",
               nbusy, excp_cause_1, mem_addr_1, excp_out_1, epc_out_1);
    end
  endtask

  task automatic test_back_to_back();
    int nepc, nbusy;
    @(negedge clk);
    excp_overflow = 1'b1;
    pc_in = 32'h0000_0200;
    mem_rdata = 8'h44;
    q1.push_back('{epc: 32'h0000_01FC, excp: 32'h0000_0044, addr: 32'd254, cause: 2'd2});
    q1.push_back('{epc: 32'h0000_01FC, excp: 32'h0000_0044, addr: 32'd254, cause: 2'd2});
    nepc = 0; nbusy = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy_1) nbusy++;
      if (epc_write_1) begin
        nepc++;
        if (nepc == 2) excp_overflow = 1'b0;
      end
    end
    excp_overflow = 1'b0;
    n_vec++;
    if (nepc != 2 || nbusy != 6) begin
      n_err++;
      $display("FAIL back_to_back: epcw=%0d busy=%0d, required 2 6", nepc, nbusy);
    end
  endtask

  task automatic test_abort();
    int npcw;
    @(negedge clk);
    excp_overflow = 1'b1;
    pc_in = 32'h0000_0030;
    mem_rdata = 8'h99;
    @(negedge clk);
    excp_overflow = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_rd_1 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_in_read: mem_rd=%b, required 1", mem_rd_1);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_addr_1, mem_rd_1, epc_out_1, epc_write_1, excp_out_1, pc_source_1, pc_write_1,
         excp_cause_1, busy_1} !== 105'd0) begin
      n_err++;
      $display("FAIL abort_zero: addr=%h rd=%b epc=%h busy=%b cause=%0d, required all zero",
               mem_addr_1, mem_rd_1, epc_out_1, busy_1, excp_cause_1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    npcw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pc_write_1 || busy_1) npcw++;
    end
    n_vec++;
    if (npcw != 0) begin
      n_err++;
      $display("FAIL abort_no_resume: %0d cycles with pc_write/busy, required 0", npcw);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_simultaneous();
    test_latency();
    test_wrap_hold();
    test_back_to_back();
    test_abort();
    repeat (2) @(negedge clk);
    n_vec++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d expected jumps never seen, required 0/0",
               q1.size(), q3.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
